// File: rtl/dec_pkg.sv
// Shared decode definitions: opcode numbers, control-word layout, the per-opcode
// control table, MD/BS encodings and the decode FSM state type.
package dec_pkg;

  localparam int OPC_NOP  = 0;
  localparam int OPC_ADD  = 1;
  localparam int OPC_OUT  = 2;
  localparam int OPC_SLT  = 3;
  localparam int OPC_AND  = 4;
  localparam int OPC_LD   = 5;
  localparam int OPC_SBI  = 6;
  localparam int OPC_LSL  = 7;
  localparam int OPC_IN   = 8;
  localparam int OPC_XRI  = 9;
  localparam int OPC_ADI  = 10;
  localparam int OPC_BZ   = 11;
  localparam int OPC_BNZ  = 12;
  localparam int OPC_ST   = 13;
  localparam int OPC_MOVA = 14;
  localparam int OPC_JMP  = 15;
  localparam int OPC_JML  = 16;
  localparam int NUM_OPC  = 17;

  localparam logic [1:0] BS_NEXT = 2'b00;
  localparam logic [1:0] BS_COND = 2'b01;
  localparam logic [1:0] BS_TRAP = 2'b10;
  localparam logic [1:0] BS_JUMP = 2'b11;

  localparam logic [1:0] MD_FU  = 2'b00;
  localparam logic [1:0] MD_MEM = 2'b01;
  localparam logic [1:0] MD_IN  = 2'b10;
  localparam logic [1:0] MD_PC1 = 2'b11;

  localparam logic [3:0] FS_PASS = 4'd0;
  localparam logic [3:0] FS_ADD  = 4'd1;
  localparam logic [3:0] FS_SUB  = 4'd2;
  localparam logic [3:0] FS_AND  = 4'd3;
  localparam logic [3:0] FS_XOR  = 4'd4;
  localparam logic [3:0] FS_LSL  = 4'd5;
  localparam logic [3:0] FS_SLT  = 4'd6;

  typedef enum logic {RUN = 1'b0, JML_JUMP = 1'b1} state_e;

  typedef struct packed {
    logic [1:0] bs;
    logic       ps;
    logic       mw;
    logic       rw;
    logic       ma;
    logic       mb;
    logic [1:0] md;
    logic [3:0] fs;
    logic       cs;
    logic       oe;
  } uop_ctrl_t;

  // use_* flags say which instruction fields pass through; the rest are forced to 0.
  typedef struct packed {
    logic      use_da;
    logic      use_aa;
    logic      use_ba;
    logic      use_sh;
    uop_ctrl_t ctl;
  } ctrl_word_t;

  function automatic ctrl_word_t cw(input logic [3:0] use_f, input logic [1:0] bs,
                                    input logic ps, input logic mw, input logic rw,
                                    input logic ma, input logic mb, input logic [1:0] md,
                                    input logic [3:0] fs, input logic cs, input logic oe);
    cw = '{use_f[3], use_f[2], use_f[1], use_f[0], '{bs, ps, mw, rw, ma, mb, md, fs, cs, oe}};
  endfunction

  localparam ctrl_word_t CTRL_TABLE [NUM_OPC] = '{
    cw(4'b0000, BS_NEXT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, MD_FU,  FS_PASS, 1'b0, 1'b0), // NOP
    cw(4'b1110, BS_NEXT, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, MD_FU,  FS_ADD,  1'b0, 1'b0), // ADD
    cw(4'b0100, BS_NEXT, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, MD_FU,  FS_PASS, 1'b0, 1'b1), // OUT
    cw(4'b1110, BS_NEXT, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, MD_FU,  FS_SLT,  1'b0, 1'b0), // SLT
    cw(4'b1110, BS_NEXT, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, MD_FU,  FS_AND,  1'b0, 1'b0), // AND
    cw(4'b1100, BS_NEXT, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, MD_MEM, FS_PASS, 1'b0, 1'b0), // LD
    cw(4'b1101, BS_NEXT, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, MD_FU,  FS_SUB,  1'b0, 1'b0), // SBI
    cw(4'b1101, BS_NEXT, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, MD_FU,  FS_LSL,  1'b0, 1'b0), // LSL
    cw(4'b1000, BS_NEXT, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, MD_IN,  FS_PASS, 1'b0, 1'b0), // IN
    cw(4'b1101, BS_NEXT, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, MD_FU,  FS_XOR,  1'b0, 1'b0), // XRI
    cw(4'b1101, BS_NEXT, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, MD_FU,  FS_ADD,  1'b0, 1'b0), // ADI
    cw(4'b0101, BS_COND, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, MD_FU,  FS_PASS, 1'b1, 1'b0), // BZ
    cw(4'b0101, BS_COND, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, MD_FU,  FS_PASS, 1'b1, 1'b0), // BNZ
    cw(4'b0110, BS_NEXT, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, MD_FU,  FS_PASS, 1'b0, 1'b0), // ST
    cw(4'b1100, BS_NEXT, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, MD_FU,  FS_PASS, 1'b0, 1'b0), // MOVA
    cw(4'b0001, BS_JUMP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, MD_FU,  FS_PASS, 1'b1, 1'b0), // JMP
    cw(4'b0000, BS_NEXT, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, MD_PC1, FS_PASS, 1'b0, 1'b0)  // JML link
  };

endpackage

// File: rtl/dec_if.sv
// Decode stage bus: upstream instruction handshake plus the downstream micro-op.
interface dec_if #(
  parameter int INST_W = 17,
  parameter int REG_AW = 3
);
  logic [INST_W-1:0] inst_in;
  logic              in_valid;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [REG_AW-1:0] DA, AA, BA;
  logic [1:0]        BS;
  logic              PS, MW, RW, MA, MB;
  logic [1:0]        MD;
  logic [3:0]        FS;
  logic [2:0]        SH;
  logic              CS, OE;
  logic              illegal;

  modport master (
    output inst_in, in_valid, out_ready,
    input  in_ready, out_valid, DA, AA, BA, BS, PS, MW, RW, MA, MB, MD, FS, SH, CS, OE, illegal
  );

  modport slave (
    input  inst_in, in_valid, out_ready,
    output in_ready, out_valid, DA, AA, BA, BS, PS, MW, RW, MA, MB, MD, FS, SH, CS, OE, illegal
  );
endinterface

// File: rtl/dec_ctrl_lut.sv
// Combinational instruction field split and control-table lookup.
// With DECODE_ILLEGAL_TRAP_EN defined, undefined opcodes produce the trap control word.
module dec_ctrl_lut
  import dec_pkg::*;
#(
  parameter int INST_W   = 17,
  parameter int OPC_W    = 5,
  parameter int REG_AW   = 3,
  parameter int LINK_REG = 7
) (
  input  logic [INST_W-1:0] inst,
  output uop_ctrl_t         ctl,
  output logic [REG_AW-1:0] da,
  output logic [REG_AW-1:0] aa,
  output logic [REG_AW-1:0] ba,
  output logic [2:0]        sh,
  output logic              illegal,
  output logic              is_jml
);
  localparam int BA_LO = 3;
  localparam int AA_LO = 3 + REG_AW;
  localparam int DA_LO = 3 + 2 * REG_AW;

  logic [OPC_W-1:0] opc;
  ctrl_word_t       cw_sel;

  assign opc = inst[INST_W-1 -: OPC_W];

  always_comb begin
    cw_sel  = CTRL_TABLE[OPC_NOP];
    illegal = 1'b0;
    if (int'(opc) < NUM_OPC) begin
      cw_sel = CTRL_TABLE[int'(opc)];
    end else begin
      illegal = 1'b1;
`ifdef DECODE_ILLEGAL_TRAP_EN
      cw_sel.ctl.bs = BS_TRAP;
      cw_sel.ctl.cs = 1'b1;
`endif
    end
    is_jml = (int'(opc) == OPC_JML);
    ctl    = cw_sel.ctl;
    da     = cw_sel.use_da ? inst[DA_LO +: REG_AW] : '0;
    aa     = cw_sel.use_aa ? inst[AA_LO +: REG_AW] : '0;
    ba     = cw_sel.use_ba ? inst[BA_LO +: REG_AW] : '0;
    sh     = cw_sel.use_sh ? inst[2:0] : 3'b000;
    // The JML link half always writes the return address into the link register.
    if (is_jml) da = REG_AW'(LINK_REG);
  end
endmodule

// File: rtl/decode_stage.sv
// Decode stage: registered micro-op with valid/ready handshake; JML is split into link + jump.
// DECODE_ILLEGAL_TRAP_EN: illegal opcodes emit a trap micro-op and stall intake until flush.
module decode_stage
  import dec_pkg::*;
#(
  parameter int INST_W   = 17,
  parameter int OPC_W    = 5,
  parameter int REG_AW   = 3,
  parameter int LINK_REG = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  dec_if.slave bus
);
  localparam int FLD_W = INST_W - OPC_W;

  state_e            state, state_nxt;
  logic              out_valid, valid_nxt, link_held, trap_hold;
  logic              in_ready, accept, consume, load;
  logic [FLD_W-1:0]  held_fields;
  logic [INST_W-1:0] lut_inst;
  uop_ctrl_t         lut_ctl, ctl_r;
  logic [REG_AW-1:0] lut_da, lut_aa, lut_ba, da_r, aa_r, ba_r;
  logic [2:0]        lut_sh, sh_r;
  logic              lut_illegal, lut_jml, illegal_r;

  // While splitting a JML, the lookup sees the held fields re-tagged as a JMP.
  assign lut_inst = (state == JML_JUMP) ? {OPC_W'(OPC_JMP), held_fields} : bus.inst_in;

  dec_ctrl_lut #(
    .INST_W(INST_W), .OPC_W(OPC_W), .REG_AW(REG_AW), .LINK_REG(LINK_REG)
  ) u_lut (
    .inst(lut_inst), .ctl(lut_ctl), .da(lut_da), .aa(lut_aa), .ba(lut_ba),
    .sh(lut_sh), .illegal(lut_illegal), .is_jml(lut_jml)
  );

  assign in_ready = rst_n && !flush && (state == RUN) && !trap_hold && (!out_valid || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign consume  = out_valid && bus.out_ready;

  always_comb begin
    state_nxt = state;
    valid_nxt = out_valid;
    load      = 1'b0;
    if (flush) begin
      state_nxt = RUN;
      valid_nxt = 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (accept) begin
            load      = 1'b1;
            valid_nxt = 1'b1;
            if (lut_jml) state_nxt = JML_JUMP;
          end else if (consume) begin
            valid_nxt = 1'b0;
          end
        end
        JML_JUMP: begin
          if (consume) begin
            if (link_held) begin
              load      = 1'b1;
              valid_nxt = 1'b1;
            end else begin
              valid_nxt = 1'b0;
              state_nxt = RUN;
            end
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      out_valid <= 1'b0;
      link_held <= 1'b0;
      ctl_r     <= '0;
      da_r      <= '0;
      aa_r      <= '0;
      ba_r      <= '0;
      sh_r      <= '0;
      illegal_r <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= valid_nxt;
      if (load) begin
        ctl_r     <= lut_ctl;
        da_r      <= lut_da;
        aa_r      <= lut_aa;
        ba_r      <= lut_ba;
        sh_r      <= lut_sh;
        illegal_r <= lut_illegal;
      end
      if (flush)       link_held <= 1'b0;
      else if (accept) link_held <= lut_jml;
      else if (load)   link_held <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) held_fields <= bus.inst_in[FLD_W-1:0];
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (!rst_n || flush)          trap_hold <= 1'b0;
    else if (accept && lut_illegal) trap_hold <= 1'b1;
  end
`else
  assign trap_hold = 1'b0;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.DA        = da_r;
  assign bus.AA        = aa_r;
  assign bus.BA        = ba_r;
  assign bus.SH        = sh_r;
  assign bus.BS        = ctl_r.bs;
  assign bus.PS        = ctl_r.ps;
  assign bus.MW        = ctl_r.mw;
  assign bus.RW        = ctl_r.rw;
  assign bus.MA        = ctl_r.ma;
  assign bus.MB        = ctl_r.mb;
  assign bus.MD        = ctl_r.md;
  assign bus.FS        = ctl_r.fs;
  assign bus.CS        = ctl_r.cs;
  assign bus.OE        = ctl_r.oe;
  assign bus.illegal   = illegal_r;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: per-opcode vector table plus handshake, JML, flush,
// illegal-opcode and reset sequences (DECODE_ILLEGAL_TRAP_EN selects trap expectations).
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   total = 0;
  int   bad   = 0;

  dec_if #(.INST_W(17), .REG_AW(3)) bus ();

  decode_stage #(.INST_W(17), .OPC_W(5), .REG_AW(3), .LINK_REG(7)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [27:0] act_w;
  assign act_w = {bus.illegal, bus.OE, bus.CS, bus.MD, bus.FS, bus.MB, bus.MA, bus.RW,
                  bus.MW, bus.PS, bus.BS, bus.SH, bus.BA, bus.AA, bus.DA};

  function automatic logic [27:0] mk(input int da, input int aa, input int ba, input int sh,
                                     input int bs, input int ps, input int mw, input int rw,
                                     input int ma, input int mb, input int md, input int fs,
                                     input int cs, input int oe, input int ill);
    mk = {1'(ill), 1'(oe), 1'(cs), 2'(md), 4'(fs), 1'(mb), 1'(ma), 1'(rw), 1'(mw), 1'(ps),
          2'(bs), 3'(sh), 3'(ba), 3'(aa), 3'(da)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [16:0] inst;
    logic [27:0] exp;
  } vec_t;

  vec_t        vt[16];
  logic [27:0] w_ld, w_add, w_link, w_jump, w_ill;

  initial begin
    // Fields 0xA9D: DA=5, AA=2, BA=3, SH=5
    vt[0]  = '{17'h01A98,         mk(5,2,3,0, 0,0,0,1,0,0,0,1,0,0,0)}; // ADD R5<=R2+R3
    vt[1]  = '{{5'd5,  12'hA9D},  mk(5,2,0,0, 0,0,0,1,0,0,1,0,0,0,0)}; // LD
    vt[2]  = '{{5'd13, 12'hA9D},  mk(0,2,3,0, 0,0,1,0,0,0,0,0,0,0,0)}; // ST
    vt[3]  = '{{5'd0,  12'hA9D},  mk(0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0)}; // NOP
    vt[4]  = '{{5'd2,  12'hA9D},  mk(0,2,0,0, 0,0,0,0,0,0,0,0,0,1,0)}; // OUT
    vt[5]  = '{{5'd3,  12'hA9D},  mk(5,2,3,0, 0,0,0,1,0,0,0,6,0,0,0)}; // SLT
    vt[6]  = '{{5'd4,  12'hA9D},  mk(5,2,3,0, 0,0,0,1,0,0,0,3,0,0,0)}; // AND
    vt[7]  = '{{5'd6,  12'hA9D},  mk(5,2,0,5, 0,0,0,1,0,1,0,2,0,0,0)}; // SBI
    vt[8]  = '{{5'd7,  12'hA9D},  mk(5,2,0,5, 0,0,0,1,0,0,0,5,0,0,0)}; // LSL
    vt[9]  = '{{5'd8,  12'hA9D},  mk(5,0,0,0, 0,0,0,1,0,0,2,0,0,0,0)}; // IN
    vt[10] = '{{5'd9,  12'hA9D},  mk(5,2,0,5, 0,0,0,1,0,1,0,4,0,0,0)}; // XRI
    vt[11] = '{{5'd10, 12'hA9D},  mk(5,2,0,5, 0,0,0,1,0,1,0,1,0,0,0)}; // ADI
    vt[12] = '{{5'd11, 12'hA9D},  mk(0,2,0,5, 1,0,0,0,0,0,0,0,1,0,0)}; // BZ
    vt[13] = '{{5'd12, 12'hA9D},  mk(0,2,0,5, 1,1,0,0,0,0,0,0,1,0,0)}; // BNZ
    vt[14] = '{{5'd14, 12'hA9D},  mk(5,2,0,0, 0,0,0,1,0,0,0,0,0,0,0)}; // MOVA
    vt[15] = '{{5'd15, 12'hA9D},  mk(0,0,0,5, 3,0,0,0,0,1,0,0,1,0,0)}; // JMP
    w_ld   = vt[1].exp;
    w_add  = vt[0].exp;
    w_link = mk(7,0,0,0, 0,0,0,1,0,0,3,0,0,0,0);
    w_jump = mk(0,0,0,5, 3,0,0,0,0,1,0,0,1,0,0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    w_ill  = mk(0,0,0,0, 2,0,0,0,0,0,0,0,1,0,1);
`else
    w_ill  = mk(0,0,0,0, 0,0,0,0,0,0,0,0,0,0,1);
`endif

    // Reset with a pending input
    rst_n = 1'b0; flush = 1'b0;
    bus.inst_in = 17'h01A98; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick; tick;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_word", act_w, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    rst_n = 1'b1; bus.in_valid = 1'b0;
    tick;
    chk("idle_valid", bus.out_valid, 0);
    chk("idle_in_ready", bus.in_ready, 1);

    // Back-to-back table, full throughput
    for (int i = 0; i < 16; i++) begin
      bus.inst_in = vt[i].inst; bus.in_valid = 1'b1;
      #1;
      chk($sformatf("v%0d_in_ready", i), bus.in_ready, 1);
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), bus.out_valid, 1);
      chk($sformatf("v%0d_word", i), act_w, vt[i].exp);
    end
    bus.in_valid = 1'b0;
    tick;
    chk("drain_valid", bus.out_valid, 0);

    // Backpressure while holding LD
    bus.inst_in = vt[1].inst; bus.in_valid = 1'b1;
    tick;
    bus.out_ready = 1'b0; bus.inst_in = vt[2].inst;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d_in_ready", k), bus.in_ready, 0);
      tick;
      chk($sformatf("bp%0d_valid", k), bus.out_valid, 1);
      chk($sformatf("bp%0d_word", k), act_w, w_ld);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick;
    chk("bp_release_valid", bus.out_valid, 0);

    // JML: link then jump, intake blocked for both
    bus.inst_in = {5'd16, 12'hA9D}; bus.in_valid = 1'b1;
    tick;
    chk("jml_link_valid", bus.out_valid, 1);
    chk("jml_link_word", act_w, w_link);
    bus.inst_in = 17'h01A98;
    #1;
    chk("jml_link_in_ready", bus.in_ready, 0);
    tick;
    chk("jml_jump_valid", bus.out_valid, 1);
    chk("jml_jump_word", act_w, w_jump);
    chk("jml_jump_in_ready", bus.in_ready, 0);
    tick;
    chk("jml_after_valid", bus.out_valid, 0);
    chk("jml_after_in_ready", bus.in_ready, 1);
    tick;
    chk("jml_next_word", act_w, w_add);
    bus.in_valid = 1'b0;
    tick;

    // JML with flush between link and jump
    bus.inst_in = {5'd16, 12'hA9D}; bus.in_valid = 1'b1;
    tick;
    chk("jmlf_link_word", act_w, w_link);
    bus.in_valid = 1'b0; flush = 1'b1;
    #1;
    chk("jmlf_flush_in_ready", bus.in_ready, 0);
    tick;
    chk("jmlf_flush_valid", bus.out_valid, 0);
    flush = 1'b0;
    tick;
    chk("jmlf_no_jump", bus.out_valid, 0);
    chk("jmlf_in_ready", bus.in_ready, 1);

    // Flush drops a same-cycle input
    bus.inst_in = 17'h01A98; bus.in_valid = 1'b1; flush = 1'b1;
    #1;
    chk("flush_in_ready", bus.in_ready, 0);
    tick;
    chk("flush_drop_valid", bus.out_valid, 0);
    flush = 1'b0; bus.in_valid = 1'b0;
    tick;

    // Illegal opcode 31
    bus.inst_in = {5'd31, 12'hA9D}; bus.in_valid = 1'b1;
    tick;
    chk("ill31_valid", bus.out_valid, 1);
    chk("ill31_word", act_w, w_ill);
`ifdef DECODE_ILLEGAL_TRAP_EN
    bus.inst_in = 17'h01A98;
    #1;
    chk("trap_in_ready", bus.in_ready, 0);
    tick;
    chk("trap_consumed_valid", bus.out_valid, 0);
    chk("trap_stall_in_ready", bus.in_ready, 0);
    bus.in_valid = 1'b0; flush = 1'b1;
    tick;
    flush = 1'b0;
    #1;
    chk("trap_flush_in_ready", bus.in_ready, 1);
`else
    bus.inst_in = {5'd17, 12'hA9D};
    #1;
    chk("ill_in_ready", bus.in_ready, 1);
    tick;
    chk("ill17_valid", bus.out_valid, 1);
    chk("ill17_word", act_w, w_ill);
    bus.inst_in = 17'h01A98;
    tick;
    chk("ill_continue_word", act_w, w_add);
    bus.in_valid = 1'b0;
`endif
    tick;

    // Reset during JML_JUMP
    bus.inst_in = {5'd16, 12'hA9D}; bus.in_valid = 1'b1;
    tick;
    chk("rstj_link_word", act_w, w_link);
    bus.in_valid = 1'b0; rst_n = 1'b0;
    #1;
    chk("rstj_in_ready", bus.in_ready, 0);
    tick;
    chk("rstj_valid", bus.out_valid, 0);
    chk("rstj_word", act_w, 0);
    rst_n = 1'b1;
    tick;
    chk("rstj_no_jump", bus.out_valid, 0);
    chk("rstj_run_in_ready", bus.in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
